// File: rtl/imem_loader_if.sv
// Byte-link receive handshake plus instruction-memory write port of the loader.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a LE 32-bit word count followed by LE
// instruction words over a byte link and writes them to memory, holding the CPU.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_req,
    imem_loader_if.slave            bus,
    output logic                    cpu_hold,
    output logic                    load_done,
    output logic                    load_err,
    output logic [$clog2(DEPTH):0]  words_written
);
    localparam int unsigned WW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LEN, DATA, WRITE, DONE, ABORT
    } state_t;

    state_t          state, state_next;
    logic [31:0]     shift_q;
    logic [31:0]     len_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      bcnt_q;
    logic [TW-1:0]   tcnt_q;

    logic            rx_ready_c;
    logic            xfer;
    logic            last_byte;
    logic            timed_out;
    logic [31:0]     assembled;
    logic [WW-1:0]   ww_inc;

    assign rx_ready_c = (state == LEN) || (state == DATA);
    assign xfer       = bus.rx_valid && rx_ready_c;
    assign last_byte  = (bcnt_q == 2'd3);
    assign timed_out  = !xfer && (tcnt_q == TW'(TIMEOUT - 1));
    // Byte n of a group lands in [8n+7:8n] once all four have shifted in.
    assign assembled  = {bus.rx_data, shift_q[31:8]};
    assign ww_inc     = words_written + WW'(1);

    assign bus.rx_ready   = rx_ready_c;
    assign bus.imem_we    = (state == WRITE);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_hold       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (load_req) state_next = LEN;
            LEN: begin
                if (xfer && last_byte) begin
                    if (assembled == '0)               state_next = DONE;
                    else if (assembled > 32'(DEPTH))   state_next = ABORT;
                    else                               state_next = DATA;
                end else if (timed_out) begin
                    state_next = ABORT;
                end
            end
            DATA: begin
                if (xfer && last_byte) state_next = WRITE;
                else if (timed_out)    state_next = ABORT;
            end
            WRITE: state_next = (32'(ww_inc) == len_q) ? DONE : DATA;
            DONE:  state_next = IDLE;
            ABORT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q       <= '0;
            len_q         <= '0;
            addr_q        <= BASE_ADDR;
            wdata_q       <= '0;
            bcnt_q        <= '0;
            tcnt_q        <= '0;
            words_written <= '0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_req) begin
                        load_done     <= 1'b0;
                        load_err      <= 1'b0;
                        words_written <= '0;
                        addr_q        <= BASE_ADDR;
                        shift_q       <= '0;
                        len_q         <= '0;
                        bcnt_q        <= '0;
                        tcnt_q        <= '0;
                    end
                end
                LEN, DATA: begin
                    if (xfer) begin
                        shift_q <= assembled;
                        bcnt_q  <= bcnt_q + 2'd1;
                        tcnt_q  <= '0;
                        if (last_byte) begin
                            if (state == LEN) len_q   <= assembled;
                            else              wdata_q <= assembled;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                WRITE: begin
                    words_written <= ww_inc;
                    addr_q        <= addr_q + 32'd4;
                end
                default: ;
            endcase
            // Flags go high while DONE/ABORT is presented and stay until the next load.
            if (state_next == DONE)  load_done <= 1'b1;
            if (state_next == ABORT) load_err  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes go into a scoreboard
// queue, a negedge monitor pops and compares each imem_we pulse.
module tb_imem_loader;
    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic        cpu_hold, load_done, load_err;
    logic [10:0] words_written;

    imem_loader_if bus ();

    imem_loader #(
        .BASE_ADDR (32'h0000_0000),
        .DEPTH     (1024),
        .TIMEOUT   (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_req      (load_req),
        .bus           (bus),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_err      (load_err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.imem_we === 1'b1) begin
            wr_t w;
            chk("rx_ready_in_write", {31'b0, bus.rx_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", bus.imem_addr, 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                chk("write_addr", bus.imem_addr, w.addr);
                chk("write_data", bus.imem_wdata, w.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int unsigned n = 0;
        if (gap) @(negedge clk);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rx_ready_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[], input bit gap);
        foreach (s[i]) send_byte(s[i], gap);
    endtask

    task automatic start_load();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        @(negedge clk);
        while (cpu_hold !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk(name, 32'd0, 32'd1);
    endtask

    task automatic chk_flags(input string tag, input logic done, input logic err,
                             input logic [10:0] ww);
        chk({tag, "_done"}, {31'b0, load_done}, {31'b0, done});
        chk({tag, "_err"},  {31'b0, load_err},  {31'b0, err});
        chk({tag, "_ww"},   {21'b0, words_written}, {21'b0, ww});
        chk({tag, "_hold"}, {31'b0, cpu_hold}, 32'd0);
    endtask

    initial begin
        logic [7:0] s_two[];
        logic [7:0] s_big[];
        logic [7:0] s_tmo[];
        logic [7:0] s_part[];
        logic [7:0] s_one[];
        logic [7:0] s_zero[];

        s_two  = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'hB3, 8'h00, 8'h52, 8'h00};
        s_big  = '{8'h01, 8'h04, 8'h00, 8'h00};
        s_tmo  = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h55, 8'h66};
        s_part = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        s_one  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        s_zero = '{8'h00, 8'h00, 8'h00, 8'h00};

        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", {31'b0, bus.rx_ready}, 32'd0);
        chk("rst_we",    {31'b0, bus.imem_we}, 32'd0);
        chk("rst_addr",  bus.imem_addr, 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        chk_flags("rst", 1'b0, 1'b0, 11'd0);

        // Two words, back-to-back bytes
        exp_q.push_back('{32'h0, 32'h0000_0013});
        exp_q.push_back('{32'h4, 32'h0052_00B3});
        start_load();
        chk("load_hold", {31'b0, cpu_hold}, 32'd1);
        send_stream(s_two, 1'b0);
        wait_idle("t1_idle_timeout");
        chk_flags("t1", 1'b1, 1'b0, 11'd2);

        // Same stream with a bubble between bytes
        exp_q.push_back('{32'h0, 32'h0000_0013});
        exp_q.push_back('{32'h4, 32'h0052_00B3});
        start_load();
        send_stream(s_two, 1'b1);
        wait_idle("t2_idle_timeout");
        chk_flags("t2", 1'b1, 1'b0, 11'd2);

        // N = 1025 exceeds capacity
        start_load();
        send_stream(s_big, 1'b0);
        wait_idle("t3_idle_timeout");
        chk_flags("t3", 1'b0, 1'b1, 11'd0);

        // N = 3, stream stalls mid second word
        exp_q.push_back('{32'h0, 32'h4433_2211});
        start_load();
        send_stream(s_tmo, 1'b0);
        wait_idle("t4_idle_timeout");
        chk_flags("t4", 1'b0, 1'b1, 11'd1);

        // Reset after two bytes of the first word
        start_load();
        send_stream(s_part, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", {31'b0, bus.rx_ready}, 32'd0);
        chk("mid_rst_addr",  bus.imem_addr, 32'd0);
        chk("mid_rst_wdata", bus.imem_wdata, 32'd0);
        chk_flags("mid_rst", 1'b0, 1'b0, 11'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back('{32'h0, 32'hDEAD_BEEF});
        start_load();
        send_stream(s_one, 1'b0);
        wait_idle("t5_idle_timeout");
        chk_flags("t5", 1'b1, 1'b0, 11'd1);

        // Zero length with load_req held: DONE, IDLE, then LEN again
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        send_stream(s_zero, 1'b0);
        @(negedge clk);
        chk("t6_done_state_done", {31'b0, load_done}, 32'd1);
        chk("t6_done_state_hold", {31'b0, cpu_hold}, 32'd1);
        @(negedge clk);
        chk("t6_idle_done", {31'b0, load_done}, 32'd1);
        chk("t6_idle_hold", {31'b0, cpu_hold}, 32'd0);
        @(negedge clk);
        chk("t6_relen_done", {31'b0, load_done}, 32'd0);
        chk("t6_relen_hold", {31'b0, cpu_hold}, 32'd1);
        load_req = 1'b0;
        send_stream(s_zero, 1'b0);
        wait_idle("t6_idle_timeout");
        chk_flags("t6", 1'b1, 1'b0, 11'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1);
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory load port: takes a byte stream (UART/debug), assembles little-endian 32-bit words and drives the memory's write address, write data and write-enable (`start`) pins.
- Holds the CPU pipeline (`cpu_hold`) while loading.
- Sits between the host byte-link receiver and the instruction memory. The pipeline fetch path stays on the memory's read port.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written.
- DEPTH, 1024, memory capacity in words; the largest legal word count.
- TIMEOUT, 100000, max idle cycles between accepted bytes before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- load_req  in  1  level request to begin a load, sampled in IDLE only.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  one-cycle write strobe, drives the memory `start` pin.
- imem_addr  out  32  byte address of the write (memory indexes address>>2).
- imem_wdata  out  32  assembled instruction word, drives memory instr_in.
- cpu_hold  out  1  stall/hold pipeline while a load is in progress.
- load_done  out  1  sticky: last load completed without error.
- load_err  out  1  sticky: last load aborted.
- words_written  out  11  words written in the current/last load (width = clog2(DEPTH)+1).

Behaviour:
- Reset: all registered state is cleared when rst_n=0 on a clk edge.
  - State goes to IDLE.
  - rx_ready, imem_we, cpu_hold, load_done and load_err go to 0.
  - imem_addr is set to BASE_ADDR; imem_wdata and words_written are set to 0.
  - Byte counter, word counter, length register and timeout counter are cleared.
- Reset mid-load: the partial word is discarded and nothing further is written. Words already written remain in memory.
- Byte transfer: occurs only on a clk edge where rx_valid=1 and rx_ready=1. Each transfer reloads the timeout counter.
- Assembly order is little-endian: byte0 goes to [7:0], byte1 to [15:8], byte2 to [23:16], byte3 to [31:24].
- State IDLE:
  - rx_ready=0, cpu_hold=0.
  - load_req=1 moves to LEN, with the following side effects:
    - cpu_hold=1 from the next cycle.
    - load_done and load_err are cleared.
    - words_written is set to 0.
    - The address pointer is set to BASE_ADDR.
- State LEN:
  - rx_ready=1; accepts 4 bytes into the 32-bit length N (LE).
  - After the 4th byte, the next state is chosen as follows:
    - N=0: go to DONE (success, no writes).
    - N>DEPTH: go to ABORT.
    - Otherwise: go to DATA.
- State DATA:
  - rx_ready=1; accepts 4 bytes into the word register.
  - The 4th accepted byte moves to WRITE on the next cycle.
- State WRITE (exactly 1 cycle):
  - rx_ready=0.
  - imem_we=1, imem_addr = BASE_ADDR + 4*words_written, imem_wdata = assembled word.
  - On exit, words_written increments.
  - If words_written reaches N after the increment, go to DONE; otherwise go to DATA.
  - The data-to-write latency is 1 cycle after the 4th byte's handshake edge.
- State DONE (1 cycle): load_done=1 (sticky), cpu_hold drops to 0 on the exit edge, then go to IDLE.
- State ABORT (1 cycle): load_err=1 (sticky), no write, cpu_hold drops, then go to IDLE.
- Timeout: in LEN or DATA, the counter increments on each cycle with no transfer. When it reaches TIMEOUT, go to ABORT; the partial word is discarded.
- imem_we is 0 in every state except WRITE.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- load_req is ignored outside IDLE.
- If load_req is still high on return to IDLE, a new load starts the next cycle and the sticky flags are cleared.
- Address arithmetic is 32-bit. With N≤DEPTH, the last address is BASE_ADDR+4*(N-1); no wrap occurs.

Test Plan:
- Reset then load_req=1, stream `02 00 00 00 13 00 00 00 B3 00 52 00`:
  - Writes 32'h00000013 at addr 0x0 and 32'h005200B3 at addr 0x4, each with a single-cycle imem_we.
  - Then load_done=1, words_written=2, cpu_hold=0.
- Same stream with rx_valid toggled 1/0 every cycle:
  - Identical writes; no byte is lost or duplicated.
  - rx_ready=0 during each WRITE cycle.
- Length bytes `01 04 00 00` (N=1025 > DEPTH):
  - No imem_we pulse ever; load_err=1, load_done=0, cpu_hold=0.
- N=3 with only 6 data bytes sent, then idle for TIMEOUT cycles:
  - Exactly 1 write (addr 0x0); load_err=1, words_written=1.
- rst_n=0 for one cycle after 2 bytes of word 1:
  - All outputs return to reset values; no further writes.
  - A fresh load then succeeds starting at BASE_ADDR.
- Length `00 00 00 00`:
  - load_done=1 with zero writes.
  - load_req held high re-enters LEN the cycle after IDLE is reached, clearing load_done.
